// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode values and FSM state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int OPC_W = 3;

  // Instruction opcodes (top OPC_W bits of the IR)
  localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
  localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
  localparam logic [OPC_W-1:0] OP_AND = 3'd3;
  localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
  localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
  localparam logic [OPC_W-1:0] OP_STO = 3'd6;
  localparam logic [OPC_W-1:0] OP_JMP = 3'd7;

  // FSM state encoding
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH_HI = 3'd1;
  localparam logic [STATE_W-1:0] ST_FETCH_LO = 3'd2;
  localparam logic [STATE_W-1:0] ST_DECODE   = 3'd3;
  localparam logic [STATE_W-1:0] ST_EXEC_RD  = 3'd4;
  localparam logic [STATE_W-1:0] ST_EXEC_WR  = 3'd5;
  localparam logic [STATE_W-1:0] ST_HALTED   = 3'd6;

endpackage

// File: rtl/acc_alu.sv
// Accumulator ALU: ADD/AND/XOR/LDA result and ADD carry-out for the CPU core.
// Latency: combinational.
// Backpressure: none; the core decides when the result is committed.
// Ports: op (opcode), acc (accumulator), operand (memory word) in;
//        result (new accumulator value), carry (bit DATA_W of acc+operand) out.
module acc_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPC_W-1:0]  op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = {1'b0, acc} + {1'b0, operand};
    result = acc;
    carry  = sum[DATA_W];
    case (op)
      OP_ADD:  result = sum[DATA_W-1:0];
      OP_AND:  result = acc & operand;
      OP_XOR:  result = acc ^ operand;
      OP_LDA:  result = operand;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU: 8-opcode ISA, two-word instructions, split memory bus.
// Latency: ALU/LDA/STO 4 cycles, JMP/SKZ/HLT 3 cycles, +1 per wait cycle per access.
// Backpressure: mem_ready=0 holds state, addr, rd/wr and data_out indefinitely.
// Ports: clk/reset (sync, active-high); addr/rd/wr/data_out/data_oe/data_in/mem_ready
//        memory bus; fetch/opcode/ir_addr/pc_addr/carry/zero/halt status; resume
//        leaves HALTED. Optional CPU_TRACE_EN adds retire/retire_pc/instr_cnt.
module acc_cpu_core
  import cpu_pkg::*;
#(
  parameter int          DATA_W = 8,
  parameter int          ADDR_W = 13,
  parameter int unsigned RST_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr,
  output logic              rd,
  output logic              wr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic              mem_ready,
  output logic              fetch,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              carry,
  output logic              zero,
  output logic              halt,
`ifdef CPU_TRACE_EN
  output logic              retire,
  output logic [ADDR_W-1:0] retire_pc,
  output logic [31:0]       instr_cnt,
`endif
  input  logic              resume
);

  localparam int IR_W = 2 * DATA_W;

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [IR_W-1:0]    ir_q, ir_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               carry_q, carry_d;

  logic [DATA_W-1:0]  alu_result;
  logic               alu_carry;

  // Bits between the opcode and address fields carry no meaning.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q;

  assign opcode  = ir_q[IR_W-1 -: OPC_W];
  assign ir_addr = ir_q[ADDR_W-1:0];
  assign pc_addr = pc_q;
  assign carry   = carry_q;
  assign zero    = (acc_q == '0);

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (opcode),
    .acc     (acc_q),
    .operand (data_in),
    .result  (alu_result),
    .carry   (alu_carry)
  );

  // Bus outputs depend on the state register only.
  always_comb begin
    rd       = 1'b0;
    wr       = 1'b0;
    fetch    = 1'b0;
    halt     = 1'b0;
    addr     = pc_q;
    data_out = acc_q;
    case (state_q)
      ST_FETCH_HI, ST_FETCH_LO: begin
        rd    = 1'b1;
        fetch = 1'b1;
      end
      ST_EXEC_RD: begin
        rd   = 1'b1;
        addr = ir_addr;
      end
      ST_EXEC_WR: begin
        wr   = 1'b1;
        addr = ir_addr;
      end
      ST_HALTED: halt = 1'b1;
      default: ;
    endcase
    data_oe = wr;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH_HI;
      ST_FETCH_HI: if (mem_ready) begin
        ir_d[IR_W-1 -: DATA_W] = data_in;
        pc_d    = pc_q + 1'b1;
        state_d = ST_FETCH_LO;
      end
      ST_FETCH_LO: if (mem_ready) begin
        ir_d[DATA_W-1:0] = data_in;
        pc_d    = pc_q + 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_XOR, OP_LDA: state_d = ST_EXEC_RD;
          OP_STO: state_d = ST_EXEC_WR;
          OP_JMP: begin
            pc_d    = ir_addr;
            state_d = ST_FETCH_HI;
          end
          OP_SKZ: begin
            if (zero) pc_d = pc_q + ADDR_W'(2);
            state_d = ST_FETCH_HI;
          end
          default: state_d = ST_HALTED;
        endcase
      end
      ST_EXEC_RD: if (mem_ready) begin
        acc_d = alu_result;
        if (opcode == OP_ADD) carry_d = alu_carry;
        state_d = ST_FETCH_HI;
      end
      ST_EXEC_WR: if (mem_ready) state_d = ST_FETCH_HI;
      ST_HALTED:  if (resume) state_d = ST_FETCH_HI;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= ADDR_W'(RST_PC);
      ir_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

`ifdef CPU_TRACE_EN
  // Retire is registered so no output has a combinational path from mem_ready.
  logic [ADDR_W-1:0] start_pc_q, start_pc_d;
  logic              retire_q, retire_d;
  logic [ADDR_W-1:0] retire_pc_q, retire_pc_d;
  logic [31:0]       instr_cnt_q, instr_cnt_d;

  always_comb begin
    start_pc_d  = start_pc_q;
    retire_d    = 1'b0;
    retire_pc_d = retire_pc_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q == ST_FETCH_HI && mem_ready) start_pc_d = pc_q;
    case (state_q)
      ST_DECODE:  retire_d = (opcode == OP_JMP) || (opcode == OP_SKZ) || (opcode == OP_HLT);
      ST_EXEC_RD,
      ST_EXEC_WR: retire_d = mem_ready;
      default:    retire_d = 1'b0;
    endcase
    if (retire_d) begin
      retire_pc_d = start_pc_q;
      instr_cnt_d = instr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_pc_q  <= ADDR_W'(RST_PC);
      retire_q    <= 1'b0;
      retire_pc_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      start_pc_q  <= start_pc_d;
      retire_q    <= retire_d;
      retire_pc_q <= retire_pc_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign retire    = retire_q;
  assign retire_pc = retire_pc_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule
